// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default
// operand width and the quotient returned on a divide-by-zero.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MAX_WIDTH     = 16;

  // The quotient reported for a zero divisor is all ones at any legal width.
  // Callers take the low WIDTH bits.
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div_pkg

// File: rtl/sub_borrow_chain.sv
// Combinational N-bit subtractor, diff = a - b, computed as a + ~b + 1.
// It uses a generate/propagate carry chain.
//   a, b      : N-bit unsigned operands
//   diff      : N-bit difference, modulo 2^N
//   no_borrow : carry-out of the chain; 1 when a >= b
module sub_borrow_chain #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic         carry;

  // Generate and propagate are taken against the inverted subtrahend.
  assign g = a & ~b;
  assign p = ~(a ^ b);

  // Ripple the carry from a carry-in of 1. This is the +1 of two's complement.
  always_comb begin
    carry = 1'b1;
    diff  = '0;
    for (int i = 0; i < int'(N); i++) begin
      diff[i] = p[i] ^ carry;
      carry   = g[i] | (p[i] & carry);
    end
    no_borrow = carry;
  end

endmodule : sub_borrow_chain

// File: rtl/seq_divider8.sv
// Iterative unsigned restoring divider. It produces one quotient bit per
// clock and finishes in WIDTH RUN cycles. It uses a start/ready/done handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, taken only while ready is high
//   dividend, divisor   : operands, captured on the accepting edge
//   ready               : high in IDLE
//   done                : one-cycle pulse when results become valid
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : set when the last operation had a zero divisor
module seq_divider8
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    rem_q, rem_d;
  // The dividend register also collects the quotient bits. The dividend
  // bits shift out at the top and the quotient bits shift in at the bottom.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_d, remn_d;
  logic             dbz_d, done_d, ready_d;

  logic [RW-1:0]    shifted;
  logic [RW-1:0]    diff;
  logic             no_borrow;

  // The restored partial remainder is always below the divisor.
  // Shifting out its top bit therefore never loses information.
  assign shifted = (rem_q << 1) | RW'(dvd_q[WIDTH-1]);

  // Trial subtraction for the current iteration.
  sub_borrow_chain #(
    .N (RW)
  ) u_sub (
    .a         (shifted),
    .b         ({1'b0, dvs_q}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quotient;
    remn_d  = remainder;
    dbz_d   = div_by_zero;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            quo_d   = DBZ_QUOTIENT[WIDTH-1:0];
            remn_d  = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      RUN: begin
        rem_d = no_borrow ? diff : shifted;
        dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          quo_d   = dvd_d;
          remn_d  = rem_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // The handshake outputs are registered from the next state.
    // They then line up exactly with the state they describe.
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      ready       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quotient    <= quo_d;
      remainder   <= remn_d;
      div_by_zero <= dbz_d;
      done        <= done_d;
      ready       <= ready_d;
    end
  end

endmodule : seq_divider8

// File: tb/tb_seq_divider8.sv
// Directed and randomised checks for seq_divider8 at WIDTH = 8.
// Latency is counted in edges after the accepting edge E0.
// A normal divide is expected to raise done on E0+8 (the 9th edge including E0).
// A zero divisor is expected to raise done on E0 itself.
module tb_seq_divider8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called right after an edge while the DUT is in IDLE. Issues one operation
  // and checks the latency, the results and the single-cycle done pulse.
  // Returns at posedge+1 of the IDLE cycle that follows DONE.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edbz, input int lat);
    int n;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'hxx;
    divisor  = 8'hxx;
    check({tag, "_busy"}, 32'(ready), 32'd0);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_rdy"}, 32'(ready), 32'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int cyc, ndone;
    logic prev_done;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    #23;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal, worst-case digits, divisor larger than dividend.
    do_op("200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
    do_op("255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    do_op("5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
    do_op("255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
    do_op("128_129", 8'd128, 8'd129, 8'd0, 8'd128, 1'b0, 8);

    // Divide by zero, then a normal operation clears the flag.
    do_op("37_0", 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 0);
    do_op("10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 8);

    // A start pulse during RUN and another during DONE must both be ignored.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 8'd2;
      end
      if (k == 4) start = 1'b0;
      if (k < 8) check("ign_early_done", 32'(done), 32'd0);
    end
    check("ign_done", 32'(done), 32'd1);
    check("ign_q", 32'(quotient), 32'd28);
    check("ign_r", 32'(remainder), 32'd4);
    start    = 1'b1;
    dividend = 8'd99;
    divisor  = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_done_rdy", 32'(ready), 32'd1);
    check("ign_done_q", 32'(quotient), 32'd28);
    @(posedge clk); #1;
    check("ign_idle_rdy", 32'(ready), 32'd1);

    // Asynchronous reset in the middle of RUN.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(ready), 32'd1);
    do_op("100_10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 8);

    // Random sweep with nonzero divisors.
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      do_op("rnd", ra, rb, ra / rb, ra % rb, 1'b0, 8);
      check("rnd_identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
      check("rnd_rem_lt", 32'(remainder < rb), 32'd1);
    end

    // Back-to-back with start held high. Done is expected every 10 cycles.
    start     = 1'b1;
    dividend  = 8'd50;
    divisor   = 8'd5;
    cyc       = 0;
    ndone     = 0;
    prev_done = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        check("b2b_cycle", 32'(cyc), 32'(9 + 10 * ndone));
        check("b2b_width", 32'(prev_done), 32'd0);
        check("b2b_q", 32'(quotient), 32'd10);
        ndone++;
      end
      prev_done = done;
    end
    check("b2b_count", 32'(ndone), 32'd3);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("b2b_end_ready", 32'(ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_divider8
